// File: rtl/clk_ratio_pkg.sv
// Shared definitions for the clock-ratio detector family.
//   state_e          : measurement FSM states.
//   LOCK_COUNT_MIN/MAX: legal range of the lock threshold.
//   MATCH_W          : width of the consecutive-match counter (holds up to 15).
//   lock_count_clamp : forces an out-of-range lock threshold into the legal range.
package clk_ratio_pkg;

   typedef enum logic [1:0] {
      WAIT    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } state_e;

   localparam int LOCK_COUNT_MIN = 1;
   localparam int LOCK_COUNT_MAX = 15;
   localparam int MATCH_W        = 4;

   function automatic int lock_count_clamp(input int n);
      if (n < LOCK_COUNT_MIN) return LOCK_COUNT_MIN;
      if (n > LOCK_COUNT_MAX) return LOCK_COUNT_MAX;
      return n;
   endfunction

endpackage

// File: rtl/clk_ratio_detect_sync_edge.sv
// sync_edge: multi-flop synchronizer plus rising-edge detector for an
// asynchronous level input.
//   clk_i : sampling clock
//   rst   : synchronous active-high reset, clears all flops to 0
//   d_i   : asynchronous input
//   lvl   : synchronized level (last synchronizer stage)
//   rise  : one-cycle pulse when lvl goes 0 -> 1
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst,
   input  logic d_i,
   output logic lvl,
   output logic rise
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              lvl_q, lvl_d;

   always_comb begin
      // Shift chain: bit 0 captures the raw input, the top bit is the level.
      sync_d = (sync_q << 1) | STAGES'(d_i);
      lvl_d  = sync_q[STAGES-1];
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         sync_q <= '0;
         lvl_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         lvl_q  <= lvl_d;
      end
   end

   assign lvl  = sync_q[STAGES-1];
   assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/clk_ratio_detect.sv
// clk_ratio_detect: measures the period and high time of a divided clock
// sig_i in clk_i cycles and flags lock once the period is stable.
//   clk_i     : reference clock
//   rst       : synchronous active-high reset
//   sig_i     : asynchronous divided clock under measurement
//   period_o  : last rise-to-rise period in clk_i cycles
//   high_o    : cycles sig_i was sampled high within that period
//   stb_o     : one-cycle pulse when period_o/high_o update
//   valid_o   : a measurement has been published since reset/timeout
//   locked_o  : period stable for LOCK_COUNT consecutive measurements
//   timeout_o : no rising edge within 2^CNT_W-1 cycles
module clk_ratio_detect
   import clk_ratio_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             sig_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             stb_o,
   output logic             valid_o,
   output logic             locked_o,
   output logic             timeout_o
);

   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam int                 LOCK_N   = lock_count_clamp(LOCK_COUNT);
   localparam logic [MATCH_W-1:0] LOCK_SAT = MATCH_W'(LOCK_N);
   localparam logic [MATCH_W-1:0] LOCK_THR = MATCH_W'(LOCK_N - 1);

   logic lvl, rise;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
      .clk_i (clk_i),
      .rst   (rst),
      .d_i   (sig_i),
      .lvl   (lvl),
      .rise  (rise)
   );

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   hcnt_q, hcnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               stb_q, stb_d;
   logic               valid_q, valid_d;
   logic               locked_q, locked_d;
   logic               timeout_q, timeout_d;

   always_comb begin
      // Counters run in every state; a rise always restarts them at 1 so the
      // rise cycle itself is the first cycle of the new period.
      cnt_d  = rise ? CNT_ONE : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
      hcnt_d = rise ? CNT_ONE : ((lvl && (hcnt_q != CNT_MAX)) ? hcnt_q + 1'b1 : hcnt_q);

      state_d   = state_q;
      period_d  = period_q;
      high_d    = high_q;
      match_d   = match_q;
      stb_d     = 1'b0;
      valid_d   = valid_q;
      locked_d  = locked_q;
      timeout_d = timeout_q;

      case (state_q)
         WAIT: begin
            // First edge only opens the measurement window.
            if (rise) state_d = MEASURE;
         end
         MEASURE: begin
            if (rise) begin
               period_d = cnt_q;
               high_d   = hcnt_q;
               stb_d    = 1'b1;
               valid_d  = 1'b1;
               if ((cnt_q == period_q) && valid_q)
                  match_d = (match_q == LOCK_SAT) ? match_q : match_q + 1'b1;
               else
                  match_d = '0;
               // The publish just made is itself the first of LOCK_N periods.
               locked_d = (match_d >= LOCK_THR);
            end else if (cnt_q == CNT_MAX) begin
               state_d   = TIMEOUT;
               timeout_d = 1'b1;
               valid_d   = 1'b0;
               locked_d  = 1'b0;
               match_d   = '0;
            end
         end
         TIMEOUT: begin
            if (rise) begin
               state_d   = MEASURE;
               timeout_d = 1'b0;
            end
         end
         default: state_d = WAIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q   <= WAIT;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         match_q   <= '0;
         stb_q     <= 1'b0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         match_q   <= match_d;
         stb_q     <= stb_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign period_o  = period_q;
   assign high_o    = high_q;
   assign stb_o     = stb_q;
   assign valid_o   = valid_q;
   assign locked_o  = locked_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Bench for clk_ratio_detect: a default-width instance for ratio/lock tests
// and a CNT_W=4 instance for timeout behaviour. Expected publishes
// {period, high, locked} are queued by the stimulus; monitors pop them on
// every stb_o.
module tb_clk_ratio_detect;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sig, sig4, sig_dut;
   logic [7:0] period, high;
   logic       stb, valid, locked, timeout;
   logic [3:0] period4, high4;
   logic       stb4, valid4, locked4, timeout4;

   // Divide-by-3 reference divider running on the same clock (output 100).
   logic       div_en = 1'b0;
   logic [1:0] div_cnt = 2'd0;
   logic       div_out;
   always @(posedge clk) begin
      if (!div_en) div_cnt <= 2'd0;
      else         div_cnt <= (div_cnt == 2'd2) ? 2'd0 : div_cnt + 2'd1;
   end
   assign div_out = div_en && (div_cnt == 2'd0);
   assign sig_dut = sig | div_out;

   clk_ratio_detect dut (
      .clk_i(clk), .rst(rst), .sig_i(sig_dut),
      .period_o(period), .high_o(high), .stb_o(stb),
      .valid_o(valid), .locked_o(locked), .timeout_o(timeout)
   );

   clk_ratio_detect #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst(rst), .sig_i(sig4),
      .period_o(period4), .high_o(high4), .stb_o(stb4),
      .valid_o(valid4), .locked_o(locked4), .timeout_o(timeout4)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [16:0] exp_q[$];
   logic [16:0] exp4_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic push_exp(input int p, input int h, input int l, input bit to4, input int reps);
      repeat (reps) begin
         if (to4) exp4_q.push_back({8'(p), 8'(h), 1'(l)});
         else     exp_q.push_back({8'(p), 8'(h), 1'(l)});
      end
   endtask

   // Drives a len-bit pattern (MSB first) reps times, one bit per clock.
   task automatic drive_pat(input logic [7:0] bits, input int len, input int reps, input bit to4);
      repeat (reps) begin
         for (int i = len - 1; i >= 0; i--) begin
            if (to4) sig4 = bits[i];
            else     sig  = bits[i];
            tick();
         end
      end
      sig  = 1'b0;
      sig4 = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Scoreboard monitors.
   always @(negedge clk) begin
      logic [16:0] e;
      if (stb) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_stb: got period=%0d high=%0d, required no strobe", period, high);
         end else begin
            e = exp_q.pop_front();
            check("pub_period", int'(period), int'(e[16:9]));
            check("pub_high",   int'(high),   int'(e[8:1]));
            check("pub_locked", int'(locked), int'(e[0]));
         end
      end
      if (stb4) begin
         if (exp4_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_stb4: got period=%0d high=%0d, required no strobe", period4, high4);
         end else begin
            e = exp4_q.pop_front();
            check("pub4_period", int'(period4), int'(e[16:9]));
            check("pub4_high",   int'(high4),   int'(e[8:1]));
            check("pub4_locked", int'(locked4), int'(e[0]));
         end
      end
   end

   initial begin
      bit got;
      rst = 1'b1; sig = 1'b0; sig4 = 1'b0;
      idle(3);
      check("rst_period",  int'(period),  0);
      check("rst_high",    int'(high),    0);
      check("rst_stb",     int'(stb),     0);
      check("rst_valid",   int'(valid),   0);
      check("rst_locked",  int'(locked),  0);
      check("rst_timeout", int'(timeout), 0);
      check("rst4_timeout", int'(timeout4), 0);
      rst = 1'b0;

      // Pattern 110: period 3, high 2, lock on 4th publish.
      push_exp(3, 2, 0, 0, 3);
      push_exp(3, 2, 1, 0, 2);
      drive_pat(8'b110, 3, 6, 0);
      idle(5);
      check("t1_drained", exp_q.size(), 0);
      check("t1_valid", int'(valid), 1);

      // Pattern 10000: period 5, high 1.
      do_reset();
      push_exp(5, 1, 0, 0, 3);
      drive_pat(8'b10000, 5, 4, 0);
      idle(5);
      check("t2a_drained", exp_q.size(), 0);

      // Pattern 10: minimum period 2.
      do_reset();
      push_exp(2, 1, 0, 0, 3);
      push_exp(2, 1, 1, 0, 2);
      drive_pat(8'b10, 2, 6, 0);
      idle(5);
      check("t2b_drained", exp_q.size(), 0);

      // Period change 3 -> 4 after lock.
      do_reset();
      push_exp(3, 2, 0, 0, 3);
      push_exp(3, 2, 1, 0, 3);
      push_exp(4, 2, 0, 0, 3);
      push_exp(4, 2, 1, 0, 1);
      drive_pat(8'b110, 3, 6, 0);
      drive_pat(8'b1100, 4, 5, 0);
      idle(6);
      check("t3_drained", exp_q.size(), 0);

      // CNT_W=4 instance: timeout after holding low, then recovery.
      do_reset();
      push_exp(4, 1, 0, 1, 2);
      drive_pat(8'b1000, 4, 3, 1);
      idle(8);
      check("t4_no_early_timeout", int'(timeout4), 0);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (timeout4) got = 1'b1;
      end
      check("t4_timeout", int'(timeout4), 1);
      check("t4_valid_cleared", int'(valid4), 0);
      check("t4_locked_cleared", int'(locked4), 0);
      check("t4_period_held", int'(period4), 4);
      check("t4_high_held", int'(high4), 1);
      check("t4_drained", exp4_q.size(), 0);
      push_exp(4, 1, 0, 1, 1);
      drive_pat(8'b1000, 4, 2, 1);
      check("t4_timeout_cleared", int'(timeout4), 0);
      idle(4);
      check("t4_valid_again", int'(valid4), 1);
      check("t4_drained2", exp4_q.size(), 0);

      // Mid-period reset while locked.
      do_reset();
      push_exp(3, 2, 0, 0, 3);
      push_exp(3, 2, 1, 0, 2);
      drive_pat(8'b110, 3, 6, 0);
      idle(3);
      check("t5_locked_before", int'(locked), 1);
      check("t5_drained", exp_q.size(), 0);
      do_reset();
      check("t5_period",  int'(period),  0);
      check("t5_high",    int'(high),    0);
      check("t5_stb",     int'(stb),     0);
      check("t5_valid",   int'(valid),   0);
      check("t5_locked",  int'(locked),  0);
      check("t5_timeout", int'(timeout), 0);
      push_exp(3, 2, 0, 0, 2);
      drive_pat(8'b110, 3, 3, 0);
      idle(5);
      check("t5_drained2", exp_q.size(), 0);

      // Divide-by-3 from the same clock: lock within 20 cycles.
      do_reset();
      push_exp(3, 1, 0, 0, 3);
      push_exp(3, 1, 1, 0, 3);
      div_en = 1'b1;
      got = 1'b0;
      for (int i = 1; i <= 21; i++) begin
         tick();
         if (i <= 20 && locked && period == 8'd3) got = 1'b1;
      end
      div_en = 1'b0;
      check("t6_locked_within_20", int'(got), 1);
      idle(5);
      check("t6_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
